// File: rtl/fbga_mult_pkg.sv
// rtl/fbga_mult_pkg.sv - shared definitions for the FBGA10 multiply-accumulate datapath
package fbga_mult_pkg;

   localparam int DEF_PROD_W = 16;

   // Also used by the operand sequencer; keep encodings stable.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - sums a programmed number of streamed products into a wide accumulator
module product_accumulator
   import fbga_mult_pkg::*;
#(
   parameter int PROD_W = DEF_PROD_W,
   parameter int ACC_W  = 24,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [CNT_W-1:0]  num_terms,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] product,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  acc_out,
   output logic              overflow,
   output logic              busy
);

   state_e             r_state;
   state_e             w_next_state;
   logic [ACC_W-1:0]   r_acc;
   logic               r_ovf;
   logic [CNT_W-1:0]   r_remaining;
   logic               w_xfer;
   logic [ACC_W:0]     w_sum;

   assign w_xfer = (r_state == ACCUM) && in_valid;
   // One extra bit so the carry out of ACC_W can feed the sticky overflow flag.
   assign w_sum  = {1'b0, r_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, product};

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_next_state = (num_terms != '0) ? ACCUM : DONE;
            end
         end
         ACCUM: begin
            if (w_xfer && (r_remaining == CNT_W'(1))) begin
               w_next_state = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_acc       <= '0;
         r_ovf       <= 1'b0;
         r_remaining <= '0;
      end else begin
         r_state <= w_next_state;
         if ((r_state == IDLE) && start) begin
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_remaining <= num_terms;
         end else if (w_xfer) begin
            r_acc       <= w_sum[ACC_W-1:0];
            r_ovf       <= r_ovf | w_sum[ACC_W];
            r_remaining <= r_remaining - CNT_W'(1);
         end
      end
   end

   assign in_ready  = (r_state == ACCUM);
   assign out_valid = (r_state == DONE);
   assign busy      = (r_state != IDLE);
   assign acc_out   = r_acc;
   assign overflow  = r_ovf;

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - table-driven scoreboard bench for product_accumulator
module tb_product_accumulator;

   typedef struct packed {
      logic [7:0]       nt;
      logic [3:0][15:0] p;
      logic [6:0]       vpat;
      logic [3:0]       vlen;
      logic [3:0]       stall;
      logic [23:0]      exp_acc;
      logic             exp_ovf;
      logic [16:0]      exp_acc_b;
      logic             exp_ovf_b;
   } vec_t;

   typedef struct packed {
      logic [23:0] acc;
      logic        ovf;
      logic [16:0] acc_b;
      logic        ovf_b;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  num_terms = '0;
   logic        in_valid = 1'b0;
   logic [15:0] product = '0;
   logic        out_ready = 1'b0;
   logic        in_ready, out_valid, overflow, busy;
   logic [23:0] acc_out;
   logic        in_ready_b, out_valid_b, overflow_b, busy_b;
   logic [16:0] acc_out_b;

   int   n_vec = 0;
   int   n_err = 0;
   exp_t sb[$];
   vec_t tbl[6];

   always #5 clk = ~clk;

   product_accumulator u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_terms(num_terms),
      .in_valid(in_valid), .in_ready(in_ready), .product(product),
      .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out),
      .overflow(overflow), .busy(busy)
   );

   product_accumulator #(.ACC_W(17)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .start(start), .num_terms(num_terms),
      .in_valid(in_valid), .in_ready(in_ready_b), .product(product),
      .out_valid(out_valid_b), .out_ready(out_ready), .acc_out(acc_out_b),
      .overflow(overflow_b), .busy(busy_b)
   );

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endfunction

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("res_acc",   32'(acc_out),   32'(e.acc));
            check("res_ovf",   32'(overflow),  32'(e.ovf));
            check("res_acc_b", 32'(acc_out_b), 32'(e.acc_b));
            check("res_ovf_b", 32'(overflow_b), 32'(e.ovf_b));
            check("b_ctl", {29'd0, busy_b, in_ready_b, out_valid_b}, {29'd0, busy, in_ready, out_valid});
         end
      end
   end

   task automatic run_job(input vec_t v);
      int beat;
      int cyc;
      sb.push_back('{v.exp_acc, v.exp_ovf, v.exp_acc_b, v.exp_ovf_b});
      num_terms = v.nt;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      beat = 0;
      cyc = 0;
      if (v.nt == 8'd0) begin
         in_valid = 1'b1;
         @(negedge clk);
         check("nt0_in_ready", 32'(in_ready), 32'd0);
         @(posedge clk); #1;
      end
      while (beat < int'(v.nt) && cyc < 600) begin
         in_valid = (cyc < int'(v.vlen)) ? v.vpat[cyc] : 1'b1;
         product  = v.p[beat % 4];
         @(negedge clk);
         if (in_ready && in_valid) beat++;
         cyc++;
         @(posedge clk); #1;
      end
      if (beat < int'(v.nt)) check("accum_timeout", 32'(beat), 32'(v.nt));
      in_valid = 1'b0;
      if (v.nt == 8'd0) begin
         // Start edge, then one DONE cycle already elapsed above.
         check("nt0_out_valid", 32'(out_valid), 32'd1);
      end else begin
         @(negedge clk);
         check("latency_out_valid", 32'(out_valid), 32'd1);
      end
      for (int i = 0; i < int'(v.stall); i++) begin
         @(posedge clk); #1;
         in_valid = 1'b1;
         @(negedge clk);
         check("stall_out_valid", 32'(out_valid), 32'd1);
         check("stall_in_ready",  32'(in_ready),  32'd0);
         check("stall_acc",       32'(acc_out),   32'(v.exp_acc));
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk);
      check("handoff_idle", 32'(busy), 32'd0);
   endtask

   initial begin
      vec_t v;
      tbl[0] = '{8'd2, {16'd0, 16'd0, 16'd30, 16'd20}, 7'd0, 4'd0, 4'd0,
                 24'd50, 1'b0, 17'd50, 1'b0};
      tbl[1] = '{8'd3, {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 7'd0, 4'd0, 4'd1,
                 24'h02FFFD, 1'b0, 17'h0FFFD, 1'b1};
      tbl[2] = '{8'd0, {16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD}, 7'd0, 4'd0, 4'd0,
                 24'd0, 1'b0, 17'd0, 1'b0};
      tbl[3] = '{8'd4, {16'd4, 16'd3, 16'd2, 16'd1}, 7'b1011001, 4'd7, 4'd5,
                 24'd10, 1'b0, 17'd10, 1'b0};
      tbl[4] = '{8'd4, {16'h0001, 16'hFFFF, 16'hABCD, 16'h1234}, 7'b0101010, 4'd7, 4'd0,
                 24'h01BE01, 1'b0, 17'h1BE01, 1'b0};
      tbl[5] = '{8'd255, {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 7'd0, 4'd0, 4'd0,
                 24'hFEFF01, 1'b0, 17'h0FF01, 1'b1};

      repeat (2) @(posedge clk);
      #1;
      check("rst_acc",       32'(acc_out),   32'd0);
      check("rst_ovf",       32'(overflow),  32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy",      32'(busy),      32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 6; i++) begin
         run_job(tbl[i]);
      end

      // Asynchronous reset in the middle of a job discards it.
      num_terms = 8'd4;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      in_valid = 1'b1;
      product = 16'd100;
      @(posedge clk); #1;
      product = 16'd200;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("pre_rst_acc", 32'(acc_out), 32'd300);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_acc",       32'(acc_out),   32'd0);
      check("mid_rst_busy",      32'(busy),      32'd0);
      check("mid_rst_in_ready",  32'(in_ready),  32'd0);
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      v = '{8'd1, {16'd0, 16'd0, 16'd0, 16'd7}, 7'd0, 4'd0, 4'd0, 24'd7, 1'b0, 17'd7, 1'b0};
      run_job(v);

      // start held high across a whole job and the handoff.
      sb.push_back('{24'd11, 1'b0, 17'd11, 1'b0});
      num_terms = 8'd2;
      start = 1'b1;
      @(posedge clk); #1;
      num_terms = 8'd1;
      in_valid = 1'b1;
      product = 16'd5;
      @(posedge clk); #1;
      product = 16'd6;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("hold_done_valid", 32'(out_valid), 32'd1);
         check("hold_done_acc",   32'(acc_out),   32'd11);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      sb.push_back('{24'd9, 1'b0, 17'd9, 1'b0});
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk);
      check("hold_handoff_idle", 32'(busy), 32'd0);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("hold_restart_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      product = 16'd9;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("hold_job2_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk);
      check("hold_job2_idle", 32'(busy), 32'd0);

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
